// File: rtl/fifo_rd_packer_if.sv
// FIFO read-side and packed-word stream signals of fifo_rd_packer.
// master = packer side, slave = FIFO/downstream side.
interface fifo_rd_packer_if;
  logic [7:0]  read_data;
  logic        rempty;
  logic        rinc;
  logic        flush;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] pop_count;

  modport master (
    input  read_data, rempty, flush, m_ready,
    output rinc, m_data, m_keep, m_valid, pop_count
  );

  modport slave (
    output read_data, rempty, flush, m_ready,
    input  rinc, m_data, m_keep, m_valid, pop_count
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Packs FWFT FIFO bytes into 4-lane words; word valid the edge after the 4th pop, flush emits a partial word.
// Backpressure: a held output word stalls popping only at the 4th byte; flush waits for a free output stage.
module fifo_rd_packer #(
  parameter int BYTES = 4
) (
  input  logic       rclk,
  input  logic       rrst_n,
  fifo_rd_packer_if.master bus
);

  typedef enum logic {COLLECT, FLUSH} state_t;

  state_t              state, state_n;
  logic [1:0]          idx, idx_n;
  logic [23:0]         acc, acc_n;
  logic [8*BYTES-1:0]  data_n;
  logic [BYTES-1:0]    keep_n;
  logic                valid_n;
  logic [15:0]         cnt_n;
  logic [3:0]          part_mask;
  logic                rst_sync;
  logic                out_free;
  logic                pop;

  // Single stage so the first pop can land on the 2nd edge after release.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) rst_sync <= 1'b0;
    else         rst_sync <= 1'b1;
  end

  assign out_free = !bus.m_valid || bus.m_ready;
  assign pop      = rst_sync && (state == COLLECT) && !bus.rempty &&
                    ((idx != 2'd3) || out_free);
  assign bus.rinc = pop;

  always_comb begin
    part_mask = 4'b0000;
    case (idx)
      2'd1:    part_mask = 4'b0001;
      2'd2:    part_mask = 4'b0011;
      2'd3:    part_mask = 4'b0111;
      default: part_mask = 4'b0000;
    endcase
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    acc_n   = acc;
    data_n  = bus.m_data;
    keep_n  = bus.m_keep;
    valid_n = bus.m_valid && !bus.m_ready;
    cnt_n   = bus.pop_count + {15'd0, pop};
    case (state)
      COLLECT: begin
        if (pop) begin
          case (idx)
            2'd0: acc_n[7:0]   = bus.read_data;
            2'd1: acc_n[15:8]  = bus.read_data;
            2'd2: acc_n[23:16] = bus.read_data;
            default: begin
              data_n  = {bus.read_data, acc};
              keep_n  = 4'hF;
              valid_n = 1'b1;
              acc_n   = 24'd0;
            end
          endcase
          idx_n = idx + 2'd1;
        end
        if (bus.flush) state_n = FLUSH;
      end
      FLUSH: begin
        if (idx == 2'd0) begin
          state_n = COLLECT;
        end else if (out_free) begin
          // Lanes at or above idx are still zero since the last word cleared acc.
          data_n  = {8'h00, acc};
          keep_n  = part_mask;
          valid_n = 1'b1;
          idx_n   = 2'd0;
          acc_n   = 24'd0;
          state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state         <= COLLECT;
      idx           <= 2'd0;
      acc           <= 24'd0;
      bus.m_data    <= '0;
      bus.m_keep    <= '0;
      bus.m_valid   <= 1'b0;
      bus.pop_count <= 16'd0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      acc           <= acc_n;
      bus.m_data    <= data_n;
      bus.m_keep    <= keep_n;
      bus.m_valid   <= valid_n;
      bus.pop_count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: FWFT FIFO model, expected-word scoreboard, timing checks.
module tb_fifo_rd_packer;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
  } word_t;

  logic rclk = 1'b0;
  logic rrst_n = 1'b0;

  fifo_rd_packer_if bus();

  fifo_rd_packer #(.BYTES(4)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus.master)
  );

  always #5 rclk = ~rclk;

  logic [7:0] fifo_q[$];
  word_t      exp_q[$];
  int         acc_cyc[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rinc_cnt = 0;
  int rinc_first = -1;
  int rinc_last = -1;
  logic s_rinc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    bus.rempty    = (fifo_q.size() == 0);
    bus.read_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
    word_t w;
    w.data = d;
    w.keep = k;
    exp_q.push_back(w);
  endtask

  // Inputs change only 2 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge rclk);
    #2;
  endtask

  task automatic drain(input string tag, input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || bus.m_valid) && i < budget) begin
      step(1);
      i++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic pulse_flush();
    bus.flush = 1'b1;
    step(1);
    bus.flush = 1'b0;
  endtask

  // Monitor: sample away from the active edge, score accepted words.
  always @(negedge rclk) begin
    word_t e;
    cyc++;
    s_rinc = bus.rinc;
    if (bus.rinc) begin
      rinc_cnt++;
      if (rinc_first < 0) rinc_first = cyc;
      rinc_last = cyc;
    end
    if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_word", {31'd0, bus.m_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", bus.m_data, e.data);
        chk("word_keep", {28'd0, bus.m_keep}, {28'd0, e.keep});
        acc_cyc.push_back(cyc);
      end
    end
  end

  // FIFO model pops the head just after an edge that saw rinc=1.
  always @(posedge rclk) begin
    #1;
    if (s_rinc && fifo_q.size() != 0) void'(fifo_q.pop_front());
    s_rinc = 1'b0;
    refresh();
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush   = 1'b0;
    bus.m_ready = 1'b0;
    refresh();
    #12;
    chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_m_keep", {28'd0, bus.m_keep}, 32'd0);
    chk("rst_m_data", bus.m_data, 32'd0);
    chk("rst_pop_count", {16'd0, bus.pop_count}, 32'd0);
    chk("rst_rinc", {31'd0, bus.rinc}, 32'd0);
    step(1);
    rrst_n = 1'b1;
    step(3);

    // Empty FIFO with flush pulses: no pops, no output.
    pulse_flush();
    step(2);
    pulse_flush();
    pulse_flush();
    step(3);
    chk("empty_rinc_cnt", rinc_cnt, 0);
    chk("empty_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("empty_pop_count", {16'd0, bus.pop_count}, 32'd0);

    // Basic word.
    bus.m_ready = 1'b1;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    expect_word(32'h44332211, 4'hF);
    drain("basic_drain", 40);
    chk("basic_pop_count", {16'd0, bus.pop_count}, 32'd4);

    // Backpressure: first word held, popping stalls at the 4th byte of word 2.
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h08070605, 4'hF);
    step(12);
    chk("bp_m_valid", {31'd0, bus.m_valid}, 32'd1);
    chk("bp_m_data", bus.m_data, 32'h04030201);
    chk("bp_rinc_stall", {31'd0, bus.rinc}, 32'd0);
    chk("bp_fifo_left", fifo_q.size(), 1);
    chk("bp_pop_count", {16'd0, bus.pop_count}, 32'd11);
    step(3);
    chk("bp_hold_data", bus.m_data, 32'h04030201);
    chk("bp_hold_keep", {28'd0, bus.m_keep}, 32'hF);
    bus.m_ready = 1'b1;
    drain("bp_drain", 40);
    chk("bp_pop_total", {16'd0, bus.pop_count}, 32'd12);

    // Partial flush, then flush with nothing collected.
    push_byte(8'hAA); push_byte(8'hBB);
    expect_word(32'h0000BBAA, 4'b0011);
    step(4);
    chk("fl_fifo_popped", fifo_q.size(), 0);
    chk("fl_no_early_word", {31'd0, bus.m_valid}, 32'd0);
    pulse_flush();
    drain("fl_drain", 20);
    pulse_flush();
    step(4);
    chk("fl_idle_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("fl_pop_count", {16'd0, bus.pop_count}, 32'd14);

    // Streaming: rinc every cycle, a word every 4 cycles, no bubble.
    acc_cyc.delete();
    rinc_cnt = 0;
    rinc_first = -1;
    for (int i = 0; i < 12; i++) push_byte(8'(8'h50 + i));
    expect_word(32'h53525150, 4'hF);
    expect_word(32'h57565554, 4'hF);
    expect_word(32'h5B5A5958, 4'hF);
    drain("str_drain", 40);
    chk("str_rinc_cnt", rinc_cnt, 12);
    chk("str_rinc_span", rinc_last - rinc_first, 11);
    chk("str_words", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3) begin
      chk("str_gap0", acc_cyc[1] - acc_cyc[0], 4);
      chk("str_gap1", acc_cyc[2] - acc_cyc[1], 4);
    end

    // Reset with a held word and 2 partial bytes: all discarded.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'(8'hE0 + i));
    step(10);
    chk("pre_rst_m_valid", {31'd0, bus.m_valid}, 32'd1);
    rrst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("mid_rst_m_data", bus.m_data, 32'd0);
    chk("mid_rst_m_keep", {28'd0, bus.m_keep}, 32'd0);
    chk("mid_rst_pop_count", {16'd0, bus.pop_count}, 32'd0);
    push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3); push_byte(8'hC4);
    #1;
    chk("mid_rst_rinc", {31'd0, bus.rinc}, 32'd0);
    bus.m_ready = 1'b1;
    step(2);
    rrst_n = 1'b1;
    expect_word(32'hC4C3C2C1, 4'hF);
    @(negedge rclk);
    chk("sync_gap_rinc", {31'd0, bus.rinc}, 32'd0);
    @(negedge rclk);
    chk("sync_first_rinc", {31'd0, bus.rinc}, 32'd1);
    chk("sync_fifo_full", fifo_q.size(), 4);
    step(1);
    drain("rst_drain", 40);
    chk("rst_pop_count_after", {16'd0, bus.pop_count}, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
